// File: rtl/frontpanel_pkg.sv
// -----------------------------------------------------------------------------
// frontpanel_pkg
//   Shared definitions for the multiplexed front panel: row numbering, switch
//   and key widths, key bit positions and small row helpers. Used by the switch
//   scanner, the LED multiplexer and the CPU control logic.
// -----------------------------------------------------------------------------
package frontpanel_pkg;

    localparam int NROWS    = 3;             // scanned rows
    localparam int NRET     = 6;             // shared return lines per row
    localparam int SR_W     = 12;            // switch register width
    localparam int KEY_W    = 6;             // momentary key count
    localparam int NSW      = SR_W + KEY_W;  // total debounced switches
    localparam int DB_CNT_W = 4;             // debounce counter width

    // Key bit positions within keys[] / keypress[]
    localparam int KEY_START    = 0;
    localparam int KEY_LOADADDR = 1;
    localparam int KEY_DEP      = 2;
    localparam int KEY_EXAM     = 3;
    localparam int KEY_CONT     = 4;
    localparam int KEY_STOP     = 5;

    // Row index: rows 0/1 carry SR[5:0]/SR[11:6], row 2 carries the keys
    typedef enum logic [1:0] {
        ROW_SR_LO = 2'd0,
        ROW_SR_HI = 2'd1,
        ROW_KEYS  = 2'd2
    } row_t;

    // One-hot row select pattern {row2,row1,row0}
    function automatic logic [NROWS-1:0] row_select(input row_t r);
        logic [NROWS-1:0] sel;
        sel = '0;
        case (r)
            ROW_SR_LO: sel = 3'b001;
            ROW_SR_HI: sel = 3'b010;
            ROW_KEYS:  sel = 3'b100;
            default:   sel = '0;
        endcase
        return sel;
    endfunction

    // Scan order 0 -> 1 -> 2 -> 0
    function automatic row_t row_advance(input row_t r);
        row_t nxt;
        nxt = ROW_SR_LO;
        case (r)
            ROW_SR_LO: nxt = ROW_SR_HI;
            ROW_SR_HI: nxt = ROW_KEYS;
            default:   nxt = ROW_SR_LO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Debounces one switch sampled once per scan frame. A reading that differs
//   from the stable level must be seen on DEBOUNCE_N consecutive samples before
//   it is accepted; any agreeing sample restarts the count.
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   sample  in   1-cycle strobe: raw is valid for this switch
//   raw     in   synchronised reading, 1 = closed
//   stable  out  debounced level (registered)
// -----------------------------------------------------------------------------
module sw_debounce
    import frontpanel_pkg::*;
#(
    parameter int DEBOUNCE_N = 4   // 1..15
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic raw,
    output logic stable
);

    localparam logic [DB_CNT_W-1:0] N_ACCEPT = DB_CNT_W'(DEBOUNCE_N);

    logic [DB_CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sample) begin
            if (raw == stable) begin
                count <= '0;
            end else if (count + 1'b1 == N_ACCEPT) begin
                stable <= raw;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frontpanel_switch_scanner.sv
// -----------------------------------------------------------------------------
// frontpanel_switch_scanner
//   Input side of the multiplexed front panel. Drives three one-hot row lines,
//   reads six shared active-low return lines and debounces 12 switch-register
//   toggles plus 6 momentary keys.
// Ports
//   CLK       in   1   system clock
//   RESET     in   1   asynchronous active-high reset
//   SWRET     in   6   return lines, active-low (0 = closed), async to CLK
//   SROW1     out  1   row 0 select (SR[5:0]), active-high
//   SROW2     out  1   row 1 select (SR[11:6]), active-high
//   SROW3     out  1   row 2 select (keys[5:0]), active-high
//   sr        out  12  debounced switch register, 1 = up/closed
//   keys      out  6   debounced key levels (START,LOADADDR,DEP,EXAM,CONT,STOP)
//   keypress  out  6   1-cycle pulse on each key's debounced 0->1
//   frame     out  1   1-cycle pulse after the row-2 sample (once per scan)
// -----------------------------------------------------------------------------
module frontpanel_switch_scanner
    import frontpanel_pkg::*;
#(
    parameter int SCANDIV    = 64,  // clocks per row dwell incl. blank; >= SETTLE+2
    parameter int SETTLE     = 8,   // dwell count at which returns are sampled; >= 2
    parameter int DEBOUNCE_N = 4    // consecutive differing frames to accept; 1..15
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NRET-1:0]     SWRET,
    output logic                SROW1,
    output logic                SROW2,
    output logic                SROW3,
    output logic [SR_W-1:0]     sr,
    output logic [KEY_W-1:0]    keys,
    output logic [KEY_W-1:0]    keypress,
    output logic                frame
);

    localparam int              DW           = $clog2(SCANDIV);
    localparam logic [DW-1:0]   DWELL_LAST   = DW'(SCANDIV - 1);
    localparam logic [DW-1:0]   DWELL_SAMPLE = DW'(SETTLE);

    // ---------------------------------------------------------------------
    // Return-line synchroniser; resets to all-open so nothing looks pressed
    // ---------------------------------------------------------------------
    logic [NRET-1:0] swret_meta;
    logic [NRET-1:0] swret_sync;
    logic [NRET-1:0] ret_closed;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            swret_meta <= '1;
            swret_sync <= '1;
        end else begin
            swret_meta <= SWRET;
            swret_sync <= swret_meta;
        end
    end

    assign ret_closed = ~swret_sync;

    // ---------------------------------------------------------------------
    // Dwell / row counters
    // ---------------------------------------------------------------------
    logic [DW-1:0] dwell, dwell_nxt;
    row_t          row,   row_nxt;

    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        dwell_nxt = dwell + 1'b1;
        row_nxt   = row;
        if (dwell == DWELL_LAST) begin
            dwell_nxt = '0;
            row_nxt   = row_advance(row);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dwell <= '0;
            row   <= ROW_SR_LO;
        end else begin
            dwell <= dwell_nxt;
            row   <= row_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Row drive: registered from the next counter state so the lines switch
    // cleanly on the clock edge. Reset value is the decode of row 0 / dwell 0
    // so SROW1 is up in the very first cycle after release; the RESET gate
    // holds all rows low while reset is active. The last dwell cycle is blank
    // so two rows are never driven together (break-before-make).
    // ---------------------------------------------------------------------
    logic [NROWS-1:0] srow_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            srow_q <= row_select(ROW_SR_LO);
        end else if (dwell_nxt == DWELL_LAST) begin
            srow_q <= '0;
        end else begin
            srow_q <= row_select(row_nxt);
        end
    end

    assign {SROW3, SROW2, SROW1} = srow_q & {NROWS{~RESET}};

    // ---------------------------------------------------------------------
    // Sample demux and debouncers: switch g lives on row g/NRET, line g%NRET
    // ---------------------------------------------------------------------
    logic           sample_now;
    logic [NSW-1:0] stable_all;

    assign sample_now = (dwell == DWELL_SAMPLE);

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        logic strobe;
        assign strobe = sample_now && (row == row_t'(2'(g / NRET)));

        sw_debounce #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_db (
            .clk    (CLK),
            .rst    (RESET),
            .sample (strobe),
            .raw    (ret_closed[g % NRET]),
            .stable (stable_all[g])
        );
    end

    assign sr   = stable_all[SR_W-1:0];
    assign keys = stable_all[NSW-1:SR_W];

    // ---------------------------------------------------------------------
    // Press edge detect and frame strobe. keypress combines two flops that
    // change on different edges, so it cannot glitch.
    // ---------------------------------------------------------------------
    logic [KEY_W-1:0] keys_prev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            keys_prev <= '0;
            frame     <= 1'b0;
        end else begin
            keys_prev <= keys;
            frame     <= sample_now && (row == ROW_KEYS);
        end
    end

    assign keypress = keys & ~keys_prev;

endmodule
